// File: rtl/isqrt_share_arb.sv
// Round-robin arbiter sharing one pipelined isqrt among N_REQ requesters, with a tag pipeline for routing results.
// Optional per-requester grant counters are enabled by defining ISQRT_SHARE_ARB_STATS_EN.
module isqrt_share_arb #(
  parameter int N_REQ     = 4,
  parameter int ISQRT_LAT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*32-1:0]    req_x,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   sq_x_vld,
  output logic [31:0]            sq_x,
  input  logic                   sq_y_vld,
  input  logic [15:0]            sq_y,
  output logic [N_REQ-1:0]       res_vld,
  output logic [15:0]            res,
  output logic                   tag_err,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  int unsigned      cand;

  logic             sq_x_vld_q;
  logic [31:0]      sq_x_q;
  logic [IDX_W-1:0] iss_tag_q;

  logic [ISQRT_LAT-1:0] tv_q;
  logic [IDX_W-1:0]     tt_q [ISQRT_LAT];
  logic                 last_vld;
  logic [IDX_W-1:0]     last_tag;

  logic [N_REQ-1:0] res_vld_q;
  logic [N_REQ-1:0] res_oh;
  logic [15:0]      res_q;
  logic             tag_err_q;

  // Search starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    req_rdy = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!gnt_vld && rst && req_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    if (gnt_vld) req_rdy[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= IDX_W'(N_REQ - 1);
      sq_x_vld_q <= 1'b0;
      sq_x_q     <= '0;
      iss_tag_q  <= '0;
    end else begin
      sq_x_vld_q <= gnt_vld;
      if (gnt_vld) begin
        ptr_q     <= gnt_idx;
        sq_x_q    <= req_x[32*gnt_idx +: 32];
        iss_tag_q <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tv_q <= '0;
    end else begin
      tv_q[0] <= sq_x_vld_q;
      for (int unsigned s = 1; s < ISQRT_LAT; s++) tv_q[s] <= tv_q[s-1];
    end
  end

  // Tags only move alongside a valid bit; idle slots keep stale tags to avoid toggling.
  always_ff @(posedge clk) begin
    if (sq_x_vld_q) tt_q[0] <= iss_tag_q;
    for (int unsigned s = 1; s < ISQRT_LAT; s++) begin
      if (tv_q[s-1]) tt_q[s] <= tt_q[s-1];
    end
  end

  assign last_vld = tv_q[ISQRT_LAT-1];
  assign last_tag = tt_q[ISQRT_LAT-1];

  always_comb begin
    res_oh           = '0;
    res_oh[last_tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_vld_q <= '0;
      res_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      res_vld_q <= '0;
      if (sq_y_vld && last_vld) begin
        res_vld_q <= res_oh;
        res_q     <= sq_y;
      end
      if (sq_y_vld != last_vld) tag_err_q <= 1'b1;
    end
  end

  assign sq_x_vld = sq_x_vld_q;
  assign sq_x     = sq_x_q;
  assign res_vld  = res_vld_q;
  assign res      = res_q;
  assign tag_err  = tag_err_q;

`ifdef ISQRT_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_rdy[i] && req_vld[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_isqrt_share_arb.sv
// Scoreboard bench for isqrt_share_arb: behavioural isqrt and round-robin model, results checked by a separate monitor.
module tb_isqrt_share_arb;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N-1:0]    req_rdy;
  logic            sq_x_vld;
  logic [31:0]     sq_x;
  logic            sq_y_vld;
  logic [15:0]     sq_y;
  logic [N-1:0]    res_vld;
  logic [15:0]     res;
  logic            tag_err;
  logic [N*CW-1:0] grant_cnt;

  isqrt_share_arb #(.N_REQ(N), .ISQRT_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
    .res_vld(res_vld), .res(res), .tag_err(tag_err), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endfunction

  // Largest r with r*r <= x.
  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    longint lo, hi, mid;
    lo = 0; hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'({32'b0, x})) lo = mid; else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // External isqrt model; 'early' shortens it by one cycle to force misalignment.
  bit          early = 1'b0;
  logic        pv [LAT];
  logic [31:0] px [LAT];
  initial for (int s = 0; s < LAT; s++) begin pv[s] = 1'b0; px[s] = '0; end
  always @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < LAT; s++) pv[s] <= 1'b0;
    end else begin
      for (int s = LAT-1; s > 0; s--) begin pv[s] <= pv[s-1]; px[s] <= px[s-1]; end
      pv[0] <= sq_x_vld;
      px[0] <= sq_x;
    end
  end
  assign sq_y_vld = early ? pv[LAT-2] : pv[LAT-1];
  assign sq_y     = isqrt_ref(early ? px[LAT-2] : px[LAT-1]);

  typedef struct { int owner; logic [15:0] val; int due; } exp_t;
  exp_t sbq[$];

  int          m_ptr = N-1;
  int          m_cnt [N];
  int          wt [N];
  logic        exp_sqv = 1'b0;
  logic [31:0] exp_sqx = '0;
  logic        m_err = 1'b0;
  initial for (int i = 0; i < N; i++) begin m_cnt[i] = 0; wt[i] = 0; end

  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] v;
    v = '0;
`ifdef ISQRT_SHARE_ARB_STATS_EN
    for (int i = 0; i < N; i++) v[CW*i +: CW] = CW'(m_cnt[i]);
`endif
    return v;
  endfunction

  // Reference arbiter and issue model: predicts grants, pushes expected results.
  always @(negedge clk) begin
    int g;
    int c;
    logic [N-1:0] erdy;
    chk("sq_x_vld", sq_x_vld, exp_sqv);
    chk("sq_x", sq_x, exp_sqx);
    chk("grant_cnt", grant_cnt, exp_cnt());
    g = -1;
    if (rst) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && req_vld[c]) g = c;
      end
    end
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    chk("req_rdy", req_rdy, erdy);
    for (int i = 0; i < N; i++) begin
      if (!rst || !req_vld[i] || req_rdy[i]) wt[i] = 0;
      else begin
        wt[i]++;
        chk("fair_wait", wt[i] <= N-1, 1);
      end
    end
    if (!rst) begin
      m_ptr = N-1; exp_sqv = 1'b0; exp_sqx = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (g >= 0) begin
      sbq.push_back('{owner: g, val: isqrt_ref(req_x[32*g +: 32]), due: cyc + LAT + 2});
      m_ptr = g;
      exp_sqv = 1'b1;
      exp_sqx = req_x[32*g +: 32];
      if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
    end else begin
      exp_sqv = 1'b0;
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    exp_t it;
    logic [N-1:0] eoh;
    logic sy;
    chk("tag_err", tag_err, m_err);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      it = sbq.pop_front();
      eoh = '0;
      eoh[it.owner] = 1'b1;
      chk("res_vld", res_vld, eoh);
      chk("res", res, it.val);
    end else begin
      chk("res_vld_idle", res_vld, '0);
    end
    if (!rst) begin
      sbq.delete();
      m_err = 1'b0;
    end else begin
      sy = (sbq.size() > 0 && sbq[0].due == cyc + 1);
      if (sy != sq_y_vld) begin
        m_err = 1'b1;
        if (sy) void'(sbq.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[32*i +: 32] = v;
  endtask

  initial begin
    step(3);
    rst = 1'b1;
    step(2);

    // Single requester.
    req_vld = 4'b0100; set_x(2, 32'd144);
    step(1);
    req_vld = '0;
    step(10);

    // Reset while three operations are in flight.
    req_vld = 4'b0111; set_x(0, 32'd100); set_x(1, 32'd81); set_x(2, 32'd64);
    step(3);
    req_vld = '0;
    step(1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(10);

    // All four continuously requesting.
    req_vld = 4'b1111;
    set_x(0, 32'd4); set_x(1, 32'd9); set_x(2, 32'd16); set_x(3, 32'd25);
    step(12);
    req_vld = '0;
    step(8);

    // Fairness with a toggling middle requester.
    for (int c = 0; c < 24; c++) begin
      req_vld = {1'b1, 1'b0, c[0], 1'b1};
      for (int i = 0; i < N; i++) set_x(i, $urandom);
      step(1);
    end
    req_vld = '0;
    step(8);

    // Saturation and operand extremes.
    for (int c = 0; c < 20; c++) begin
      req_vld = 4'b0010;
      set_x(1, c[0] ? 32'hFFFF_FFFF : 32'h0);
      step(1);
    end
    req_vld = '0;
    step(8);
`ifdef ISQRT_SHARE_ARB_STATS_EN
    chk("grant_cnt1_sat", grant_cnt[CW*1 +: CW], 4'd15);
`endif

    // Random traffic.
    for (int c = 0; c < 200; c++) begin
      req_vld = N'($urandom);
      for (int i = 0; i < N; i++)
        set_x(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
      step(1);
    end
    req_vld = '0;
    step(10);

    // Misaligned result valid.
    early = 1'b1;
    req_vld = 4'b0001; set_x(0, 32'd49);
    step(1);
    req_vld = '0;
    step(12);
    chk("tag_err_sticky", tag_err, 1'b1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    early = 1'b0;
    step(6);
    chk("tag_err_cleared", tag_err, 1'b0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
